sound_event_scheduler: RTL
==========================

// Module: sound_event_scheduler
// PURPOSE
//   Collects one-shot sound events from game logic and keyboard (hole, ball-to-ball, border, keys).
//   Queues them one-deep per source, picks one by fixed priority and plays each as a timed tone.
//   Drives the tone prescaler (preScaleValue) and enableSound of the audio path.
//   Sits between the game/keyboard logic and the tone generator; replaces the combinational
//   "whichever input is high now" tone selection.
// PARAMETERS
//   N_EVT        6           number of event sources (index 0 = highest priority)
//   TONE_CYCLES  2_500_000   clocks each tone is held (100 ms @ 25 MHz); must be >= 1
//   GAP_CYCLES   250_000     silent clocks between consecutive tones (10 ms); 0 allowed
// PORTS
//   clk            in   1      system clock, 25 MHz
//   resetN         in   1      asynchronous reset, active low
//   soundOn        in   1      global sound enable; low = mute and flush
//   evtReq         in   N_EVT  event request level/pulse per source; rising edge = one event
//   preScaleValue  out  10     tone prescaler to generator; 10'h000 when silent
//   enableSound    out  1      high while a tone is playing
//   busy           out  1      high in PLAY or GAP
//   pending        out  N_EVT  latched, not-yet-granted events (debug/status)
// BEHAVIOUR
//   - Event map and tones (index: source, tone):
//     0: hole, La 10'h0DD; 1: ball-ball, fa 10'h117; 2: border, si 10'h18B;
//     3: Enter, do 10'h175; 4: left/right, re 10'h14C; 5: up/down, mi 10'h128.
//   - Reset (resetN=0, async): state=IDLE; pending=0; evtReq_d=0; timer=0;
//     preScaleValue=0; enableSound=0; busy=0.
//   - Edge detect: evtReq_d <= evtReq each clk; edge = evtReq & ~evtReq_d.
//     A held level counts as one event only.
//   - Pending latch: pending <= (pending & ~grantMask) | edge.
//     If a set and a clear hit the same bit in one cycle, the set wins: the new event is kept.
//     A repeat of an already-pending event merges into it (one-deep per source).
//   - FSM (all outputs registered):
//     IDLE: if soundOn && pending!=0, grant the lowest set index, load timer=TONE_CYCLES-1,
//       set preScaleValue=LUT[idx], enableSound=1, go to PLAY.
//     PLAY: timer--. At timer==0: preScaleValue=0, enableSound=0.
//       If GAP_CYCLES>0, load timer=GAP_CYCLES-1 and go to GAP.
//       Else apply the IDLE grant rule in the same cycle (back-to-back tones, no silent clock).
//     GAP: timer--. At timer==0, apply the IDLE grant rule, or go to IDLE if nothing is pending.
//   - Latency: evtReq first sampled high at edge k -> pending bit set after edge k
//     -> enableSound=1 after edge k+1 (IDLE case).
//   - Tone length: enableSound is high for exactly TONE_CYCLES clocks.
//   - Preemption: none. A higher-priority event arriving during PLAY waits for the end of PLAY/GAP.
//   - Starvation: accepted by design (fixed priority; events are sparse).
//   - soundOn=0 (any state): next edge -> IDLE, pending=0, outputs 0; edges seen while muted are dropped.
//   - Timer width: $clog2(max(TONE_CYCLES,GAP_CYCLES)+1) bits, no wrap (reloaded before it reaches 0-1).
//   - busy = (state != IDLE).
// STRUCTURE
//   - sound_pkg: N_EVT default, evt index enum (EVT_HOLE..EVT_KEY_UD),
//     tone constants TONE_DO/RE/MI/FA/LA/SI (10-bit, 25 MHz values), FSM state enum.
//   - Sub-module sound_tone_lut: combinational idx -> 10-bit prescaler; unused idx -> 10'h000.
//   - Priority encoder and FSM inline.
// TESTING  (bench params: TONE_CYCLES=8, GAP_CYCLES=2)
//   1. Reset: resetN=0 mid-PLAY.
//      -> preScaleValue=0, enableSound=0, pending=0 immediately; idle after release.
//   2. Single event: evtReq[3] high for 5 clks at edge k.
//      -> pending[3] after k; enableSound=1, preScaleValue=10'h175 for clocks k+2..k+9; one tone only.
//   3. Priority: evtReq[4] and evtReq[0] rise in the same cycle.
//      -> 10'h0DD for 8 clks, 2 silent clks, then 10'h14C for 8 clks.
//   4. Merge and re-arm: evtReq[2] pulsed 3 times during its own tone.
//      -> exactly one extra 10'h18B tone follows the gap.
//   5. Set-vs-clear: evtReq[1] edge in the same cycle as grant of idx 1.
//      -> pending[1] stays 1; a second 10'h117 tone plays.
//   6. Mute: soundOn=0 during PLAY with pending=6'b100100.
//      -> next clk: outputs 0, pending=0, IDLE; no tone after soundOn returns.

Source files
------------

// File: rtl/sound_event_scheduler_pkg.sv
// Shared types and constants for the sound event scheduler: event sources,
// tone prescaler values for the 25 MHz tone generator and FSM states.
package sound_event_scheduler_pkg;

  localparam int N_EVT_DEFAULT = 6;
  localparam int EVT_W         = $clog2(N_EVT_DEFAULT);

  typedef enum logic [EVT_W-1:0] {
    EVT_HOLE      = 3'd0,
    EVT_BALL      = 3'd1,
    EVT_BORDER    = 3'd2,
    EVT_KEY_ENTER = 3'd3,
    EVT_KEY_LR    = 3'd4,
    EVT_KEY_UD    = 3'd5
  } evtIdx_e;

  localparam logic [9:0] TONE_DO = 10'h175;
  localparam logic [9:0] TONE_RE = 10'h14C;
  localparam logic [9:0] TONE_MI = 10'h128;
  localparam logic [9:0] TONE_FA = 10'h117;
  localparam logic [9:0] TONE_LA = 10'h0DD;
  localparam logic [9:0] TONE_SI = 10'h18B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_e;

endpackage

// File: rtl/sound_event_scheduler_tone_lut.sv
// Maps an event source index to the prescaler value of its tone.
// Indices without a tone give 10'h000 (silence).
module sound_event_scheduler_tone_lut
  import sound_event_scheduler_pkg::*;
#(
  parameter int IDX_W = EVT_W
) (
  input  logic [IDX_W-1:0] idx,
  output logic [9:0]       preScale
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    preScale = '0;
    case (int'(idx))
      int'(EVT_HOLE):      preScale = TONE_LA;
      int'(EVT_BALL):      preScale = TONE_FA;
      int'(EVT_BORDER):    preScale = TONE_SI;
      int'(EVT_KEY_ENTER): preScale = TONE_DO;
      int'(EVT_KEY_LR):    preScale = TONE_RE;
      int'(EVT_KEY_UD):    preScale = TONE_MI;
      default:             preScale = '0;
    endcase
  end

endmodule

// File: rtl/sound_event_scheduler.sv
// Latches one-shot sound events (one deep per source), grants them by fixed
// priority (index 0 first) and plays each as a timed tone followed by a gap.
module sound_event_scheduler
  import sound_event_scheduler_pkg::*;
#(
  parameter int N_EVT       = N_EVT_DEFAULT,
  parameter int TONE_CYCLES = 2_500_000,
  parameter int GAP_CYCLES  = 250_000
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             soundOn,
  input  logic [N_EVT-1:0] evtReq,
  output logic [9:0]       preScaleValue,
  output logic             enableSound,
  output logic             busy,
  output logic [N_EVT-1:0] pending
);

  localparam int MAX_CYC = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (N_EVT > 1) ? $clog2(N_EVT) : 1;

  state_e             state, stateNext;
  logic [TIMER_W-1:0] timer, timerNext;
  logic [9:0]         preScaleNext, lutValue;
  logic               enableNext;
  logic [N_EVT-1:0]   evtReqD, evtEdge, grantMask;
  logic [IDX_W-1:0]   grantIdx;
  logic               doGrant;

  assign evtEdge = evtReq & ~evtReqD;
  assign busy    = (state != S_IDLE);

  // Lowest set index wins: scan from the top so lower indices overwrite.
  always_comb begin
    grantIdx = '0;
    for (int i = N_EVT - 1; i >= 0; i--) begin
      if (pending[i]) grantIdx = IDX_W'(i);
    end
  end

  sound_event_scheduler_tone_lut #(.IDX_W(IDX_W)) uToneLut (
    .idx      (grantIdx),
    .preScale (lutValue)
  );

  always_comb begin
    stateNext    = state;
    timerNext    = timer;
    preScaleNext = preScaleValue;
    enableNext   = enableSound;
    grantMask    = '0;
    doGrant      = 1'b0;

    if (!soundOn) begin
      stateNext    = S_IDLE;
      timerNext    = '0;
      preScaleNext = '0;
      enableNext   = 1'b0;
    end else begin
      case (state)
        S_IDLE: doGrant = 1'b1;
        S_PLAY: begin
          if (timer == '0) begin
            preScaleNext = '0;
            enableNext   = 1'b0;
            if (GAP_CYCLES > 0) begin
              timerNext = TIMER_W'(GAP_CYCLES - 1);
              stateNext = S_GAP;
            end else begin
              stateNext = S_IDLE;
              doGrant   = 1'b1;
            end
          end else begin
            timerNext = timer - 1'b1;
          end
        end
        S_GAP: begin
          if (timer == '0) begin
            stateNext = S_IDLE;
            doGrant   = 1'b1;
          end else begin
            timerNext = timer - 1'b1;
          end
        end
        default: stateNext = S_IDLE;
      endcase

      // A grant overrides the IDLE fallback chosen above.
      if (doGrant && (pending != '0)) begin
        grantMask    = N_EVT'(1) << grantIdx;
        timerNext    = TIMER_W'(TONE_CYCLES - 1);
        preScaleNext = lutValue;
        enableNext   = 1'b1;
        stateNext    = S_PLAY;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state         <= S_IDLE;
      timer         <= '0;
      preScaleValue <= '0;
      enableSound   <= 1'b0;
      evtReqD       <= '0;
      pending       <= '0;
    end else begin
      state         <= stateNext;
      timer         <= timerNext;
      preScaleValue <= preScaleNext;
      enableSound   <= enableNext;
      evtReqD       <= evtReq;
      // OR-ing the edge in last lets a new event survive a same-cycle grant.
      pending       <= soundOn ? ((pending & ~grantMask) | evtEdge) : '0;
    end
  end

endmodule
